// File: rtl/board_io_csr_pkg.sv
// Shared definitions for the board I/O CSR block: CSR modify encodings,
// register offsets and the read-modify-write helper.
package board_io_csr_pkg;

   localparam logic [2:0] MOD_NONE  = 3'd0;
   localparam logic [2:0] MOD_WRITE = 3'd1;
   localparam logic [2:0] MOD_SET   = 3'd2;
   localparam logic [2:0] MOD_CLEAR = 3'd3;

   localparam logic [1:0] OFS_LEDS    = 2'd0;
   localparam logic [1:0] OFS_INPUTS  = 2'd1;
   localparam logic [1:0] OFS_EDGES   = 2'd2;
   localparam logic [1:0] OFS_IRQMASK = 2'd3;

   // New register value for a CSR modify; undefined codes leave it alone.
   function automatic logic [31:0] csr_apply(input logic [2:0]  mod,
                                             input logic [31:0] cur,
                                             input logic [31:0] wd);
      logic [31:0] res;
      case (mod)
         MOD_WRITE: res = wd;
         MOD_SET:   res = cur | wd;
         MOD_CLEAR: res = cur & ~wd;
         default:   res = cur;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/io_debounce.sv
// One input channel: two-flop synchroniser followed by a counter debouncer.
// The debounced value flips only after the synced input has disagreed with it
// for 2^WIDTH consecutive cycles; any agreement restarts the count.
module io_debounce #(
   parameter int WIDTH = 16
) (
   input  logic clk,
   input  logic rstn,
   input  logic async_in,
   output logic stable_out
);

   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1'b1);

   logic             sync1_q;
   logic             sync2_q;
   logic             stable_q;
   logic             stable_d;
   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Count disagreement cycles and flip the debounced value at the threshold.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (sync2_q == stable_q) begin
         cnt_d = {WIDTH{1'b0}};
      end else if (cnt_q == {WIDTH{1'b1}}) begin
         stable_d = ~stable_q;
         cnt_d    = {WIDTH{1'b0}};
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // Synchroniser, counter and debounced state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= {WIDTH{1'b0}};
      end else begin
         sync1_q  <= async_in;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable_out = stable_q;

endmodule

// File: rtl/board_io_csr.sv
// CSR-mapped board I/O: LEDs, debounced switches/buttons, sticky button edge
// flags and a reset sequencer. Registers at BASE_ADDR+0..+3 (LEDS, INPUTS,
// EDGES, IRQMASK). Define BOARD_IO_IRQ_EN to implement IRQMASK and irq;
// otherwise IRQMASK reads 0 (access still claimed) and irq is tied low.
module board_io_csr
   import board_io_csr_pkg::*;
#(
   parameter logic [11:0] BASE_ADDR        = 12'hBC8,
   parameter int          SW_COUNT         = 8,
   parameter int          BTN_COUNT        = 4,
   parameter int          LED_COUNT        = 8,
   parameter int          DEBOUNCE_WIDTH   = 16,
   parameter int          RESET_HOLD_WIDTH = 6
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 read,
   input  logic [2:0]           modify,
   input  logic [31:0]          wdata,
   input  logic [11:0]          addr,
   output logic [31:0]          rdata,
   output logic                 valid,
   input  logic [SW_COUNT-1:0]  sw,
   input  logic [BTN_COUNT-1:0] btn,
   input  logic                 reset_btn_n,
   output logic [LED_COUNT-1:0] leds,
   output logic                 sys_rstn,
   output logic                 irq
);

   localparam logic [RESET_HOLD_WIDTH-1:0] RH_ONE = RESET_HOLD_WIDTH'(1'b1);

   logic [SW_COUNT-1:0]         sw_db_s;
   logic [BTN_COUNT-1:0]        btn_db_s;
   logic [11:0]                 offset_s;
   logic                        hit_s;
   logic [1:0]                  sel_s;
   logic [31:0]                 rd_s;
   logic [BTN_COUNT-1:0]        edge_clr_s;

   logic [LED_COUNT-1:0]        leds_q, leds_d;
   logic [BTN_COUNT-1:0]        edges_q, edges_d;
   logic [BTN_COUNT-1:0]        btn_prev_q, btn_prev_d;
   logic                        valid_q, valid_d;
   logic [31:0]                 rdata_q, rdata_d;
`ifdef BOARD_IO_IRQ_EN
   logic [BTN_COUNT-1:0]        mask_q, mask_d;
   logic                        irq_q, irq_d;
`endif

   logic                        rb_sync1_q;
   logic                        rb_sync2_q;
   logic [RESET_HOLD_WIDTH-1:0] rh_cnt_q, rh_cnt_d;
   logic                        sys_rstn_q, sys_rstn_d;

   for (genvar i = 0; i < SW_COUNT; i++) begin : g_sw
      io_debounce #(.WIDTH(DEBOUNCE_WIDTH)) u_db (
         .clk        (clk),
         .rstn       (rstn),
         .async_in   (sw[i]),
         .stable_out (sw_db_s[i])
      );
   end

   for (genvar i = 0; i < BTN_COUNT; i++) begin : g_btn
      io_debounce #(.WIDTH(DEBOUNCE_WIDTH)) u_db (
         .clk        (clk),
         .rstn       (rstn),
         .async_in   (btn[i]),
         .stable_out (btn_db_s[i])
      );
   end

   // Address decode: the unsigned offset wraps for addresses below the base.
   always_comb begin
      offset_s = addr - BASE_ADDR;
      hit_s    = (read | (modify != MOD_NONE)) & (offset_s < 12'd4);
      sel_s    = offset_s[1:0];
   end

   // Read mux of the current (pre-modify) register values.
   always_comb begin
      rd_s = 32'd0;
      case (sel_s)
         OFS_LEDS:    rd_s[LED_COUNT-1:0]          = leds_q;
         OFS_INPUTS:  rd_s[SW_COUNT+BTN_COUNT-1:0] = {btn_db_s, sw_db_s};
         OFS_EDGES:   rd_s[BTN_COUNT-1:0]          = edges_q;
`ifdef BOARD_IO_IRQ_EN
         OFS_IRQMASK: rd_s[BTN_COUNT-1:0]          = mask_q;
`endif
         default:     rd_s = 32'd0;
      endcase
   end

   // Register updates; a new button edge wins over a same-cycle W1C.
   always_comb begin
      leds_d     = leds_q;
      edge_clr_s = {BTN_COUNT{1'b0}};
`ifdef BOARD_IO_IRQ_EN
      mask_d     = mask_q;
`endif
      if (hit_s) begin
         valid_d = 1'b1;
         rdata_d = rd_s;
         case (sel_s)
            OFS_LEDS: leds_d = LED_COUNT'(csr_apply(modify, 32'(leds_q), wdata));
            OFS_EDGES: begin
               if ((modify == MOD_WRITE) || (modify == MOD_CLEAR)) begin
                  edge_clr_s = wdata[BTN_COUNT-1:0];
               end else begin
                  edge_clr_s = {BTN_COUNT{1'b0}};
               end
            end
`ifdef BOARD_IO_IRQ_EN
            OFS_IRQMASK: mask_d = BTN_COUNT'(csr_apply(modify, 32'(mask_q), wdata));
`endif
            default: leds_d = leds_q;
         endcase
      end else begin
         valid_d = 1'b0;
         rdata_d = 32'd0;
      end
      btn_prev_d = btn_db_s;
      edges_d    = (edges_q & ~edge_clr_s) | (btn_db_s & ~btn_prev_q);
   end

   // CSR state and response registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         leds_q     <= {LED_COUNT{1'b0}};
         edges_q    <= {BTN_COUNT{1'b0}};
         btn_prev_q <= {BTN_COUNT{1'b0}};
         valid_q    <= 1'b0;
         rdata_q    <= 32'd0;
      end else begin
         leds_q     <= leds_d;
         edges_q    <= edges_d;
         btn_prev_q <= btn_prev_d;
         valid_q    <= valid_d;
         rdata_q    <= rdata_d;
      end
   end

`ifdef BOARD_IO_IRQ_EN
   // Interrupt request from any pending, unmasked button edge.
   always_comb begin
      irq_d = |(edges_q & mask_q);
   end

   // Interrupt mask and registered irq.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mask_q <= {BTN_COUNT{1'b0}};
         irq_q  <= 1'b0;
      end else begin
         mask_q <= mask_d;
         irq_q  <= irq_d;
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   // Reset hold counter; the synced button also gates sys_rstn so a press
   // drops it one cycle after synchronisation.
   always_comb begin
      if (!rb_sync2_q) begin
         rh_cnt_d = {RESET_HOLD_WIDTH{1'b0}};
      end else if (&rh_cnt_q) begin
         rh_cnt_d = rh_cnt_q;
      end else begin
         rh_cnt_d = rh_cnt_q + RH_ONE;
      end
      sys_rstn_d = rb_sync2_q & (&rh_cnt_q);
   end

   // Reset-button synchroniser, hold counter and sequenced reset output.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rb_sync1_q <= 1'b0;
         rb_sync2_q <= 1'b0;
         rh_cnt_q   <= {RESET_HOLD_WIDTH{1'b0}};
         sys_rstn_q <= 1'b0;
      end else begin
         rb_sync1_q <= reset_btn_n;
         rb_sync2_q <= rb_sync1_q;
         rh_cnt_q   <= rh_cnt_d;
         sys_rstn_q <= sys_rstn_d;
      end
   end

   assign leds     = leds_q;
   assign valid    = valid_q;
   assign rdata    = rdata_q;
   assign sys_rstn = sys_rstn_q;

endmodule

// File: tb/tb_board_io_csr.sv
// Self-checking bench for board_io_csr with short debounce/hold widths.
// A behavioural model (delay lines, run lengths, register arrays) predicts
// every output after every clock edge; directed scenarios add fixed checks.
module tb_board_io_csr;

   localparam int          SWN    = 8;
   localparam int          BTNN   = 4;
   localparam int          LEDN   = 8;
   localparam int          DBW    = 4;
   localparam int          RHW    = 3;
   localparam logic [11:0] BASE   = 12'hBC8;
   localparam int          DB_RUN = 1 << DBW;
`ifdef BOARD_IO_IRQ_EN
   localparam logic [31:0] IRQ_EXP = 32'd1;
`else
   localparam logic [31:0] IRQ_EXP = 32'd0;
`endif

   logic            clk;
   logic            rstn;
   logic            read;
   logic [2:0]      modify;
   logic [31:0]     wdata;
   logic [11:0]     addr;
   logic [31:0]     rdata;
   logic            valid;
   logic [SWN-1:0]  sw;
   logic [BTNN-1:0] btn;
   logic            reset_btn_n;
   logic [LEDN-1:0] leds;
   logic            sys_rstn;
   logic            irq;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   board_io_csr #(
      .BASE_ADDR        (BASE),
      .SW_COUNT         (SWN),
      .BTN_COUNT        (BTNN),
      .LED_COUNT        (LEDN),
      .DEBOUNCE_WIDTH   (DBW),
      .RESET_HOLD_WIDTH (RHW)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .read        (read),
      .modify      (modify),
      .wdata       (wdata),
      .addr        (addr),
      .rdata       (rdata),
      .valid       (valid),
      .sw          (sw),
      .btn         (btn),
      .reset_btn_n (reset_btn_n),
      .leds        (leds),
      .sys_rstn    (sys_rstn),
      .irq         (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [31:0]     m_leds, m_edges, m_mask, m_rdata;
   logic            m_valid, m_irq, m_sys;
   logic [SWN-1:0]  m_sw_db, m_sw_dl1, m_sw_dl2, m_sw_last;
   logic [BTNN-1:0] m_btn_db, m_btn_dl1, m_btn_dl2, m_btn_last, m_btn_prev;
   int              m_sw_run [SWN];
   int              m_btn_run [BTNN];
   logic [9:0]      m_rb_hist;   // bit k = reset_btn_n sampled k edges ago

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_leds = 32'd0; m_edges = 32'd0; m_mask = 32'd0; m_rdata = 32'd0;
      m_valid = 1'b0; m_irq = 1'b0; m_sys = 1'b0;
      m_sw_db = '0; m_sw_dl1 = '0; m_sw_dl2 = '0; m_sw_last = '0;
      m_btn_db = '0; m_btn_dl1 = '0; m_btn_dl2 = '0; m_btn_last = '0; m_btn_prev = '0;
      for (int i = 0; i < SWN; i++) m_sw_run[i] = 0;
      for (int i = 0; i < BTNN; i++) m_btn_run[i] = 0;
      m_rb_hist = 10'd0;
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_edge();
      int          a;
      int          ofs;
      bit          acc;
      logic [31:0] old_v, new_v, clr, n_leds, n_mask, n_edges;
      logic [SWN-1:0]  sw_d;
      logic [BTNN-1:0] btn_d;
      a   = int'(addr);
      ofs = a - int'(BASE);
      acc = (read || modify != 3'd0) && (ofs >= 0) && (ofs <= 3);
      n_leds = m_leds; n_mask = m_mask; clr = 32'd0;
`ifdef BOARD_IO_IRQ_EN
      m_irq = |(m_edges & m_mask);
`else
      m_irq = 1'b0;
`endif
      if (acc) begin
         case (ofs)
            0:       old_v = m_leds;
            1:       old_v = (32'(m_btn_db) << SWN) | 32'(m_sw_db);
            2:       old_v = m_edges;
            default: old_v = m_mask;
         endcase
         case (modify)
            3'd1:    new_v = wdata;
            3'd2:    new_v = old_v | wdata;
            3'd3:    new_v = old_v & ~wdata;
            default: new_v = old_v;
         endcase
         if (ofs == 0) n_leds = new_v & 32'h0000_00FF;
`ifdef BOARD_IO_IRQ_EN
         if (ofs == 3) n_mask = new_v & 32'h0000_000F;
`endif
         if (ofs == 2 && (modify == 3'd1 || modify == 3'd3)) clr = wdata;
         m_valid = 1'b1;
         m_rdata = old_v;
      end else begin
         m_valid = 1'b0;
         m_rdata = 32'd0;
      end
      n_edges = ((m_edges & ~clr) | 32'(m_btn_db & ~m_btn_prev)) & 32'h0000_000F;
      m_btn_prev = m_btn_db;
      // pins reach the debouncer two edges late; flip after DB_RUN equal samples
      sw_d = m_sw_dl2;   m_sw_dl2 = m_sw_dl1;   m_sw_dl1 = sw;
      btn_d = m_btn_dl2; m_btn_dl2 = m_btn_dl1; m_btn_dl1 = btn;
      for (int i = 0; i < SWN; i++) begin
         if (sw_d[i] == m_sw_last[i]) m_sw_run[i]++; else m_sw_run[i] = 1;
         m_sw_last[i] = sw_d[i];
         if (sw_d[i] != m_sw_db[i] && m_sw_run[i] >= DB_RUN) m_sw_db[i] = sw_d[i];
      end
      for (int i = 0; i < BTNN; i++) begin
         if (btn_d[i] == m_btn_last[i]) m_btn_run[i]++; else m_btn_run[i] = 1;
         m_btn_last[i] = btn_d[i];
         if (btn_d[i] != m_btn_db[i] && m_btn_run[i] >= DB_RUN) m_btn_db[i] = btn_d[i];
      end
      // released once the button was seen high for the last 8 synced samples
      m_rb_hist = {m_rb_hist[8:0], reset_btn_n};
      m_sys     = &m_rb_hist[9:2];
      m_leds = n_leds; m_mask = n_mask; m_edges = n_edges;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
      check_eq("leds", 32'(leds), m_leds);
      check_eq("valid", 32'(valid), 32'(m_valid));
      check_eq("rdata", rdata, m_rdata);
      check_eq("irq", 32'(irq), 32'(m_irq));
      check_eq("sys_rstn", 32'(sys_rstn), 32'(m_sys));
   endtask

   task automatic csr(input logic r, input logic [2:0] m, input logic [11:0] a, input logic [31:0] d);
      read = r; modify = m; addr = a; wdata = d;
      tick();
      read = 1'b0; modify = 3'd0;
   endtask

   initial begin
      int b;
      rstn = 1'b1; read = 1'b0; modify = 3'd0; wdata = 32'd0; addr = 12'd0;
      sw = '0; btn = '0; reset_btn_n = 1'b1;
      model_reset();
      #1 rstn = 1'b0;
      #2;
      check_eq("rst_leds", 32'(leds), 32'd0);
      check_eq("rst_rdata", rdata, 32'd0);
      check_eq("rst_valid", 32'(valid), 32'd0);
      check_eq("rst_irq", 32'(irq), 32'd0);
      check_eq("rst_sys_rstn", 32'(sys_rstn), 32'd0);
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      repeat (12) tick();
      check_eq("por_sys_rstn", 32'(sys_rstn), 32'd1);

      // LED write / set / clear with prior value returned
      csr(1'b0, 3'd1, BASE, 32'h0000_00A5);
      check_eq("led_wr", 32'(leds), 32'h0000_00A5);
      check_eq("led_wr_rd", rdata, 32'h0000_0000);
      check_eq("led_wr_valid", 32'(valid), 32'd1);
      csr(1'b0, 3'd2, BASE, 32'h0000_000A);
      check_eq("led_set", 32'(leds), 32'h0000_00AF);
      check_eq("led_set_rd", rdata, 32'h0000_00A5);
      csr(1'b0, 3'd3, BASE, 32'h0000_0005);
      check_eq("led_clr", 32'(leds), 32'h0000_00AA);
      check_eq("led_clr_rd", rdata, 32'h0000_00AF);

      // short pulses on sw[3] are filtered, a held level appears after 18 edges
      repeat (3) begin
         sw[3] = 1'b1; repeat (10) tick();
         sw[3] = 1'b0; repeat (10) tick();
      end
      csr(1'b1, 3'd0, BASE + 12'd1, 32'd0);
      check_eq("glitch_inputs", rdata, 32'd0);
      sw[3] = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         csr(1'b1, 3'd0, BASE + 12'd1, 32'd0);
         if (i == 18) check_eq("db_sw3_before", 32'(rdata[3]), 32'd0);
         if (i == 19) check_eq("db_sw3_after", 32'(rdata[3]), 32'd1);
      end

      // button edge, interrupt, and W1C racing a new edge
      csr(1'b0, 3'd1, BASE + 12'd3, 32'h0000_0002);
      btn[1] = 1'b1;
      repeat (19) tick();
      csr(1'b1, 3'd0, BASE + 12'd2, 32'd0);
      check_eq("edge_flag", rdata, 32'h0000_0002);
      check_eq("irq_on", 32'(irq), IRQ_EXP);
      btn[1] = 1'b0;
      repeat (20) tick();
      csr(1'b0, 3'd1, BASE + 12'd2, 32'h0000_0002);
      csr(1'b1, 3'd0, BASE + 12'd2, 32'd0);
      check_eq("edge_w1c", rdata, 32'd0);
      btn[1] = 1'b1;
      repeat (18) tick();
      csr(1'b0, 3'd3, BASE + 12'd2, 32'h0000_0002);
      csr(1'b1, 3'd0, BASE + 12'd2, 32'd0);
      check_eq("edge_w1c_race", rdata, 32'h0000_0002);

      // reset button: drop after sync, release 8 edges after synced release
      reset_btn_n = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         if (i == 2) check_eq("rb_still_high", 32'(sys_rstn), 32'd1);
         if (i == 3) check_eq("rb_dropped", 32'(sys_rstn), 32'd0);
      end
      reset_btn_n = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (i == 9)  check_eq("rb_hold_low", 32'(sys_rstn), 32'd0);
         if (i == 10) check_eq("rb_released", 32'(sys_rstn), 32'd1);
      end

      // out-of-range accesses
      csr(1'b0, 3'd1, BASE + 12'd4, 32'hFFFF_FFFF);
      check_eq("oor_hi_valid", 32'(valid), 32'd0);
      check_eq("oor_hi_rdata", rdata, 32'd0);
      check_eq("oor_hi_leds", 32'(leds), 32'h0000_00AA);
      csr(1'b1, 3'd1, BASE - 12'd1, 32'h0000_0000);
      check_eq("oor_lo_valid", 32'(valid), 32'd0);
      check_eq("oor_lo_rdata", rdata, 32'd0);
      check_eq("oor_lo_leds", 32'(leds), 32'h0000_00AA);

      // randomized traffic and pin activity
      repeat (3000) begin
         read   = 1'($urandom_range(0, 1));
         modify = 3'($urandom_range(0, 7));
         addr   = BASE + 12'($urandom_range(0, 5)) - 12'd1;
         if ($urandom_range(0, 15) == 0) addr = 12'($urandom);
         wdata  = $urandom;
         if ($urandom_range(0, 39) == 0) begin
            b = int'($urandom_range(0, SWN - 1));
            sw[b] = ~sw[b];
         end
         if ($urandom_range(0, 29) == 0) begin
            b = int'($urandom_range(0, BTNN - 1));
            btn[b] = ~btn[b];
         end
         if ($urandom_range(0, 299) == 0) reset_btn_n = ~reset_btn_n;
         tick();
      end
      read = 1'b0; modify = 3'd0; reset_btn_n = 1'b1;
      repeat (40) tick();

      // asynchronous reset in the middle of an access
      csr(1'b0, 3'd1, BASE, 32'h0000_003C);
      modify = 3'd1; addr = BASE; wdata = 32'h0000_0055;
      #2 rstn = 1'b0;
      #1;
      check_eq("mid_rst_leds", 32'(leds), 32'd0);
      check_eq("mid_rst_valid", 32'(valid), 32'd0);
      check_eq("mid_rst_rdata", rdata, 32'd0);
      check_eq("mid_rst_irq", 32'(irq), 32'd0);
      check_eq("mid_rst_sys_rstn", 32'(sys_rstn), 32'd0);
      model_reset();
      read = 1'b0; modify = 3'd0;
      @(posedge clk);
      @(posedge clk);
      #1 rstn = 1'b1;
      tick();
      check_eq("post_rst_valid", 32'(valid), 32'd0);
      repeat (30) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
